// File: rtl/hazard_match_tracker.sv
// hazard_match_tracker: pipelines register addresses and control bits D->E->M->W
// and produces the comparison vector and pending-PC-write flag the hazard unit needs.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   RA1D, RA2D, WA3D    decode-stage source 1, source 2 and destination registers
//   RegWriteD           decode instruction writes the register file
//   MemtoRegD           decode instruction is a load
//   PCSrcD              decode instruction writes the PC in writeback
//   CondExE             condition check passed for the instruction in E
//   flushE              bubble the D->E register on this edge
//   match[4:0]          {Dsrc==WA3E, RA1E==WA3M, RA2E==WA3M, RA1E==WA3W, RA2E==WA3W}
//   MemtoRegE           E-stage load flag
//   RegWriteM/W         effective register write in M / W
//   PCSrcW              effective PC write in W
//   PCWrPendingF        a PC-writing instruction is in D, E or M
module hazard_match_tracker #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PC_REG  = 15,
  parameter int unsigned PC_EXCL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              CondExE,
  input  logic              flushE,
  output logic [4:0]        match,
  output logic              MemtoRegE,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic              PCWrPendingF
);

  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_REG);
  localparam logic              PC_EXCL_EN = (PC_EXCL != 0);

  logic [ADDR_W-1:0] ra1_e, ra2_e, wa3_e;
  logic [ADDR_W-1:0] wa3_m, wa3_w;
  logic              regwrite_e, pcsrc_e, pcsrc_m;

  // Stage registers; flushE zeroes E control only, conditional execution gates E->M.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1_e      <= '0;
      ra2_e      <= '0;
      wa3_e      <= '0;
      regwrite_e <= 1'b0;
      MemtoRegE  <= 1'b0;
      pcsrc_e    <= 1'b0;
      wa3_m      <= '0;
      RegWriteM  <= 1'b0;
      pcsrc_m    <= 1'b0;
      wa3_w      <= '0;
      RegWriteW  <= 1'b0;
      PCSrcW     <= 1'b0;
    end else begin
      ra1_e      <= RA1D;
      ra2_e      <= RA2D;
      wa3_e      <= WA3D;
      regwrite_e <= RegWriteD & ~flushE;
      MemtoRegE  <= MemtoRegD & ~flushE;
      pcsrc_e    <= PCSrcD & ~flushE;
      wa3_m      <= wa3_e;
      RegWriteM  <= regwrite_e & CondExE;
      pcsrc_m    <= pcsrc_e & CondExE;
      wa3_w      <= wa3_m;
      RegWriteW  <= RegWriteM;
      PCSrcW     <= pcsrc_m;
    end
  end

  // A source naming the PC reads PC+8 rather than a forwarded value, so it never matches.
  function automatic logic hit(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
    return (src == dst) && !(PC_EXCL_EN && (src == PC_ADDR));
  endfunction

  // Comparisons and pending-PC flag are combinational from current stage state.
  always_comb begin
    match        = '0;
    PCWrPendingF = 1'b0;
    match[4]     = hit(RA1D, wa3_e) | hit(RA2D, wa3_e);
    match[3]     = hit(ra1_e, wa3_m);
    match[2]     = hit(ra2_e, wa3_m);
    match[1]     = hit(ra1_e, wa3_w);
    match[0]     = hit(ra2_e, wa3_w);
    PCWrPendingF = PCSrcD | pcsrc_e | pcsrc_m;
  end

endmodule

// File: tb/tb_hazard_match_tracker.sv
// tb_hazard_match_tracker: vector table plus hand sequences for reset and PC exclusion.
module tb_hazard_match_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, PCSrcD, CondExE, flushE;

  logic [4:0] match1, match0;
  logic       mtre1, rwm1, rww1, pcsw1, pend1;
  logic       mtre0, rwm0, rww0, pcsw0, pend0;

  always #5 clk = ~clk;

  hazard_match_tracker #(.ADDR_W(4), .PC_REG(15), .PC_EXCL(1)) dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .flushE(flushE), .match(match1), .MemtoRegE(mtre1),
    .RegWriteM(rwm1), .RegWriteW(rww1), .PCSrcW(pcsw1), .PCWrPendingF(pend1)
  );

  hazard_match_tracker #(.ADDR_W(4), .PC_REG(15), .PC_EXCL(0)) dut0 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .flushE(flushE), .match(match0), .MemtoRegE(mtre0),
    .RegWriteM(rwm0), .RegWriteW(rww0), .PCSrcW(pcsw0), .PCWrPendingF(pend0)
  );

  typedef struct packed {
    logic [4:0] m1;
    logic [4:0] m0;
    logic       mtre, rwm, rww, pcsw, pend;
  } exp_t;

  typedef struct {
    logic [3:0] ra1, ra2, wa3;
    logic       rw, mtr, pcs, cex, fl;
    exp_t       e;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl[NVEC];
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b required %b", nm, idx, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa3, input logic rw, input logic mtr, input logic pcs,
                      input logic cex, input logic fl, input logic [4:0] m1, input logic [4:0] m0,
                      input logic mtre, input logic rwm, input logic rww, input logic pcsw,
                      input logic pend);
    tbl[i].ra1 = ra1; tbl[i].ra2 = ra2; tbl[i].wa3 = wa3;
    tbl[i].rw = rw; tbl[i].mtr = mtr; tbl[i].pcs = pcs; tbl[i].cex = cex; tbl[i].fl = fl;
    tbl[i].e = '{m1: m1, m0: m0, mtre: mtre, rwm: rwm, rww: rww, pcsw: pcsw, pend: pend};
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic mtr, input logic pcs, input logic cex,
                       input logic fl);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs; CondExE = cex; flushE = fl;
  endtask

  task automatic check_pop(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard[%0d]: got empty queue required an entry", idx);
    end else begin
      e = sb.pop_front();
      chk("match_excl", idx, match1, e.m1);
      chk("match_noexcl", idx, match0, e.m0);
      chk("MemtoRegE", idx, {4'b0, mtre1}, {4'b0, e.mtre});
      chk("RegWriteM", idx, {4'b0, rwm1}, {4'b0, e.rwm});
      chk("RegWriteW", idx, {4'b0, rww1}, {4'b0, e.rww});
      chk("PCSrcW", idx, {4'b0, pcsw1}, {4'b0, e.pcsw});
      chk("PCWrPendingF", idx, {4'b0, pend1}, {4'b0, e.pend});
      chk("RegWriteW_noexcl", idx, {3'b0, rwm0, rww0}, {3'b0, e.rwm, e.rww});
      chk("PCSrcW_noexcl", idx, {2'b0, mtre0, pcsw0, pend0}, {2'b0, e.mtre, e.pcsw, e.pend});
    end
  endtask

  initial begin
    //       i   ra1 ra2 wa3 rw mtr pcs cex fl  match_excl match_noexcl mtrE rwM rwW pcsW pend
    setv( 0,  1,  2,  3, 1, 0, 0, 1, 0, 5'b01111, 5'b01111, 0, 0, 0, 0, 0); // ADD R3
    setv( 1,  3,  4,  6, 0, 0, 0, 1, 0, 5'b10000, 5'b10000, 0, 0, 0, 0, 0); // uses R3
    setv( 2,  3,  8,  9, 0, 0, 0, 1, 0, 5'b01000, 5'b01000, 0, 1, 0, 0, 0);
    setv( 3, 10, 11,  5, 1, 1, 0, 1, 0, 5'b00010, 5'b00010, 0, 0, 1, 0, 0); // LDR R5
    setv( 4, 12,  5, 13, 1, 0, 0, 1, 1, 5'b10000, 5'b10000, 1, 0, 0, 0, 0); // load-use, flush
    setv( 5, 12,  5, 13, 1, 0, 0, 1, 0, 5'b00100, 5'b00100, 0, 1, 0, 0, 0); // re-presented
    setv( 6,  1,  2, 15, 1, 0, 1, 1, 0, 5'b00001, 5'b00001, 0, 0, 1, 0, 1); // PC write
    setv( 7,  7,  8,  9, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 1);
    setv( 8,  7,  8,  9, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 1, 1, 0, 1);
    setv( 9,  7,  8,  9, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 0);
    setv(10,  7,  8,  2, 1, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0); // writes R2
    setv(11,  2,  8,  9, 0, 0, 0, 0, 0, 5'b10000, 5'b10000, 0, 0, 0, 0, 0); // R2 writer fails cond
    setv(12,  7,  8,  9, 0, 0, 0, 1, 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 0);
    setv(13,  7,  8, 15, 1, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0); // dest R15
    setv(14, 15,  8,  9, 0, 0, 0, 1, 0, 5'b00000, 5'b10000, 0, 0, 0, 0, 0); // src R15 in D
    setv(15,  7,  8,  9, 0, 0, 0, 1, 0, 5'b00000, 5'b01000, 0, 1, 0, 0, 0); // src R15 in E

    reset = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
    #2;
    sb.push_back('{m1: 5'b11111, m0: 5'b11111, mtre: 0, rwm: 0, rww: 0, pcsw: 0, pend: 0});
    check_pop(-1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wa3, tbl[i].rw, tbl[i].mtr, tbl[i].pcs,
            tbl[i].cex, tbl[i].fl);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      check_pop(i);
    end

    // Reset mid-stream clears registered outputs before the next edge.
    @(posedge clk);
    #1;
    drive(4'd7, 4'd8, 4'd4, 1, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_RegWriteM", 100, {4'b0, rwm1}, 5'd1);
    chk("pre_reset_RegWriteW", 100, {4'b0, rww1}, 5'd1);
    chk("pre_reset_PCSrcW", 100, {4'b0, pcsw1}, 5'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_RegWriteM", 101, {4'b0, rwm1}, 5'd0);
    chk("async_RegWriteW", 101, {4'b0, rww1}, 5'd0);
    chk("async_PCSrcW", 101, {4'b0, pcsw1}, 5'd0);
    chk("async_MemtoRegE", 101, {4'b0, mtre1}, 5'd0);
    chk("async_pend_follows_D", 101, {4'b0, pend1}, 5'd1);
    chk("async_match_excl", 101, match1, 5'b01111);
    chk("async_match_noexcl", 101, match0, 5'b01111);
    #1;
    drive(4'd7, 4'd8, 4'd4, 0, 0, 0, 1, 0);
    #1;
    chk("reset_pend_cleared", 102, {4'b0, pend1}, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_RegWriteW", 103, {4'b0, rww1}, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
